// File: rtl/clint.sv
// Core-local interrupt/exception sequencer: freezes the pipeline on ecall/ebreak/timer irq/mret,
// performs the machine-mode CSR updates, then issues a one-cycle PC redirect.
module clint #(
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342,
  parameter logic [11:0] CSR_MSTATUS = 12'h300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        inst_valid_i,
  input  logic        irq_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWMepc    = 3'd1;
  localparam logic [2:0] StWMcause  = 3'd2;
  localparam logic [2:0] StWMstatus = 3'd3;
  localparam logic [2:0] StWMret    = 3'd4;
  localparam logic [2:0] StAssert   = 3'd5;

  localparam logic [31:0] InstEcall  = 32'h0000_0073;
  localparam logic [31:0] InstEbreak = 32'h0010_0073;
  localparam logic [31:0] InstMret   = 32'h3020_0073;

  logic [2:0]  state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        mret_q, mret_d;

  logic is_ecall, is_ebreak, is_mret, irq_take;
  logic trap_trig, mret_trig;

  assign is_ecall  = inst_valid_i && (inst_i == InstEcall);
  assign is_ebreak = inst_valid_i && (inst_i == InstEbreak);
  assign is_mret   = inst_valid_i && (inst_i == InstMret);
  // The irq squashes the EX instruction, which is re-executed from epc on return.
  assign irq_take  = irq_i && csr_mstatus_i[3] && inst_valid_i &&
                     !(is_ecall || is_ebreak || is_mret);

  assign trap_trig = (state_q == StIdle) && (is_ecall || is_ebreak || irq_take);
  assign mret_trig = (state_q == StIdle) && !trap_trig && is_mret;

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    mret_d  = mret_q;
    case (state_q)
      StIdle: begin
        if (trap_trig) begin
          state_d = StWMepc;
          epc_d   = inst_addr_i;
          mret_d  = 1'b0;
          if (is_ecall)       cause_d = 32'd11;
          else if (is_ebreak) cause_d = 32'd3;
          else                cause_d = 32'h8000_0007;
        end else if (mret_trig) begin
          state_d = StWMret;
          mret_d  = 1'b1;
        end
      end
      StWMepc:    state_d = StWMcause;
      StWMcause:  state_d = StWMstatus;
      StWMstatus: state_d = StAssert;
      StWMret:    state_d = StAssert;
      StAssert:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      epc_q   <= 32'd0;
      cause_q <= 32'd0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  always_comb begin
    hold_flag_o  = 1'b0;
    csr_we_o     = 1'b0;
    csr_waddr_o  = 12'd0;
    csr_wdata_o  = 32'd0;
    int_assert_o = 1'b0;
    int_addr_o   = 32'd0;
    case (state_q)
      StIdle: hold_flag_o = trap_trig || mret_trig;
      StWMepc: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc_q;
      end
      StWMcause: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      StWMstatus: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0,
                       csr_mstatus_i[2:0]};
      end
      StWMret: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7],
                       csr_mstatus_i[2:0]};
      end
      StAssert: begin
        // Hold drops here so IF can load the redirect target.
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_mepc_i : {csr_mtvec_i[31:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint.sv
// Directed self-checking bench for clint: trap, irq, mret, priority, reset and mtvec masking.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst, inst_addr, mtvec, mepc, mstatus;
  logic        inst_valid, irq;
  logic        hold_flag, csr_we, int_assert;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, int_addr;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] Ecall  = 32'h0000_0073;
  localparam logic [31:0] Ebreak = 32'h0010_0073;
  localparam logic [31:0] Mret   = 32'h3020_0073;
  localparam logic [31:0] Nop    = 32'h0000_0013;

  always #5 clk = ~clk;

  clint dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_i       (inst),
    .inst_addr_i  (inst_addr),
    .inst_valid_i (inst_valid),
    .irq_i        (irq),
    .csr_mtvec_i  (mtvec),
    .csr_mepc_i   (mepc),
    .csr_mstatus_i(mstatus),
    .hold_flag_o  (hold_flag),
    .csr_we_o     (csr_we),
    .csr_waddr_o  (csr_waddr),
    .csr_wdata_o  (csr_wdata),
    .int_assert_o (int_assert),
    .int_addr_o   (int_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Settle combinational outputs, then compare the full output set.
  task automatic expect_out(input string tag, input logic h, input logic we,
                            input logic [11:0] wa, input logic [31:0] wd,
                            input logic ia, input logic [31:0] iaddr);
    #1;
    check({tag, ".hold"}, {31'd0, hold_flag}, {31'd0, h});
    check({tag, ".we"}, {31'd0, csr_we}, {31'd0, we});
    check({tag, ".waddr"}, {20'd0, csr_waddr}, {20'd0, wa});
    check({tag, ".wdata"}, csr_wdata, wd);
    check({tag, ".assert"}, {31'd0, int_assert}, {31'd0, ia});
    check({tag, ".iaddr"}, int_addr, iaddr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] pc, input logic v,
                       input logic q, input logic [31:0] ms);
    inst       = i;
    inst_addr  = pc;
    inst_valid = v;
    irq        = q;
    mstatus    = ms;
  endtask

  initial begin
    rst_n = 1'b0;
    mtvec = 32'h200;
    mepc  = 32'h0;
    drive(Nop, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    expect_out("reset", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    rst_n = 1'b1;
    step();
    expect_out("idle", 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // ecall at 0x100; instruction stays in EX while frozen and must be ignored
    drive(Ecall, 32'h100, 1'b1, 1'b0, 32'h8);
    expect_out("ecall.c0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    expect_out("ecall.c1", 1, 1, 12'h341, 32'h100, 0, 32'h0);
    step();
    expect_out("ecall.c2", 1, 1, 12'h342, 32'd11, 0, 32'h0);
    step();
    expect_out("ecall.c3", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    step();
    expect_out("ecall.c4", 0, 0, 12'h0, 32'h0, 1, 32'h200);
    step();
    drive(Nop, 32'h200, 1'b1, 1'b0, 32'h80);
    expect_out("ecall.c5", 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // timer interrupt with MIE=1
    drive(Nop, 32'h44, 1'b1, 1'b1, 32'h8);
    expect_out("irq.c0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    expect_out("irq.c1", 1, 1, 12'h341, 32'h44, 0, 32'h0);
    step();
    expect_out("irq.c2", 1, 1, 12'h342, 32'h8000_0007, 0, 32'h0);
    step();
    expect_out("irq.c3", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    step();
    expect_out("irq.c4", 0, 0, 12'h0, 32'h0, 1, 32'h200);
    step();

    // irq masked by MIE=0, then by a bubble in EX
    drive(Nop, 32'h44, 1'b1, 1'b1, 32'h0);
    expect_out("irq_mie0.c0", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    expect_out("irq_mie0.c1", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    drive(Nop, 32'h44, 1'b0, 1'b1, 32'h8);
    expect_out("irq_bubble.c0", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    expect_out("irq_bubble.c1", 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // mret with mstatus=0x80, mepc=0x104
    mepc = 32'h104;
    drive(Mret, 32'h500, 1'b1, 1'b0, 32'h80);
    expect_out("mret.c0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    expect_out("mret.c1", 1, 1, 12'h300, 32'h88, 0, 32'h0);
    step();
    expect_out("mret.c2", 0, 0, 12'h0, 32'h0, 1, 32'h104);
    step();
    drive(Nop, 32'h104, 1'b1, 1'b0, 32'h88);
    expect_out("mret.c3", 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // ebreak beats irq; mtvec mode bits are masked off the target
    mtvec = 32'h203;
    drive(Ebreak, 32'h300, 1'b1, 1'b1, 32'h8);
    expect_out("ebrk.c0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    expect_out("ebrk.c1", 1, 1, 12'h341, 32'h300, 0, 32'h0);
    step();
    expect_out("ebrk.c2", 1, 1, 12'h342, 32'd3, 0, 32'h0);
    step();
    expect_out("ebrk.c3", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    step();
    expect_out("ebrk.c4", 0, 0, 12'h0, 32'h0, 1, 32'h200);
    step();
    // MIE now clear: pending irq must wait
    drive(Nop, 32'h200, 1'b1, 1'b1, 32'h80);
    expect_out("pend.c0", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    // mret alongside irq: mret wins
    mepc = 32'h300;
    drive(Mret, 32'h204, 1'b1, 1'b1, 32'h80);
    expect_out("mret_irq.c0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    expect_out("mret_irq.c1", 1, 1, 12'h300, 32'h88, 0, 32'h0);
    step();
    expect_out("mret_irq.c2", 0, 0, 12'h0, 32'h0, 1, 32'h300);
    step();
    // MIE re-enabled: irq now taken
    drive(Nop, 32'h300, 1'b1, 1'b1, 32'h88);
    expect_out("retake.c0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    expect_out("retake.c1", 1, 1, 12'h341, 32'h300, 0, 32'h0);
    step();
    expect_out("retake.c2", 1, 1, 12'h342, 32'h8000_0007, 0, 32'h0);
    step();
    expect_out("retake.c3", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    step();
    expect_out("retake.c4", 0, 0, 12'h0, 32'h0, 1, 32'h200);
    step();

    // reset during W_MCAUSE aborts the sequence
    drive(Ecall, 32'h100, 1'b1, 1'b0, 32'h8);
    expect_out("rst_mid.c0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    step();
    expect_out("rst_mid.c2", 1, 1, 12'h342, 32'd11, 0, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(Nop, 32'h104, 1'b1, 1'b0, 32'h8);
    expect_out("rst_mid.c3", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    expect_out("rst_mid.c4", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    step();
    expect_out("rst_mid.c5", 0, 0, 12'h0, 32'h0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
